// File: rtl/ssbr_lane_pkg.sv
// Shared types and defaults for the shift-register lane arbiter.
package ssbr_lane_pkg;

  localparam int unsigned SSBR_WIDTH_DEF = 4;
  localparam int unsigned SSBR_CNT_W_DEF = $clog2(SSBR_WIDTH_DEF);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } ssbr_state_t;

  function automatic int unsigned ssbr_cnt_w(input int unsigned width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/rr_arb_2.sv
// Two-requester arbiter, round-robin by default, fixed priority under SSBR_ARB_FIXED_PRIO_EN.
// Latency: grant is combinational; pointer moves one cycle after accept. No backpressure of its own.
module rr_arb_2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       en,
  input  logic       accept,
  output logic [1:0] gnt
);

`ifdef SSBR_ARB_FIXED_PRIO_EN

  logic unused_arb_sig;
  assign unused_arb_sig = ^{clk, rst, accept};

  always_comb begin
    gnt = 2'b00;
    if (en) begin
      if (req[0])      gnt = 2'b01;
      else if (req[1]) gnt = 2'b10;
    end
  end

`else

  // ptr = 1 means requester 1 wins a tie
  logic ptr;

  always_comb begin
    gnt = 2'b00;
    if (en) begin
      if (req == 2'b11) gnt = ptr ? 2'b10 : 2'b01;
      else              gnt = req;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         ptr <= 1'b0;
    else if (accept) ptr <= gnt[0];
  end

`endif

endmodule

// File: rtl/ssbr_lane_arb.sv
// Shares one serial shift-register lane between two requesters; SSBR_ARB_FIXED_PRIO_EN selects fixed priority.
// Latency: WIDTH shift cycles then a one-cycle response; no response backpressure, grants only in IDLE/DONE.
module ssbr_lane_arb
  import ssbr_lane_pkg::*;
#(
  parameter int unsigned WIDTH = SSBR_WIDTH_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         req_valid,
  output logic [1:0]         req_ready,
  input  logic [1:0]         req_dir,
  input  logic [2*WIDTH-1:0] req_data,
  output logic [1:0]         rsp_valid,
  output logic [WIDTH-1:0]   rsp_data,
  output logic               ssbr_d,
  output logic               ssbr_dir,
  output logic               ssbr_shift,
  input  logic               ssbr_ql,
  input  logic               ssbr_qr,
  output logic               busy
);

  localparam int unsigned CNT_W = ssbr_cnt_w(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef struct packed {
    logic [WIDTH-1:0] word;
    logic             dir;
    logic             owner;
  } xfer_t;

  ssbr_state_t      state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] capture;
  xfer_t            xfer;

  logic [1:0] gnt;
  logic       arb_en;
  logic       acc_vld;
  logic       ret_bit;
  xfer_t      xfer_nxt;

  // Granting is blocked while reset is held so req_ready reads 0 during reset.
  assign arb_en  = ((state == ST_IDLE) || (state == ST_DONE)) && !rst;
  assign acc_vld = |(req_valid & gnt);

  rr_arb_2 u_arb (
    .clk    (clk),
    .rst    (rst),
    .req    (req_valid),
    .en     (arb_en),
    .accept (acc_vld),
    .gnt    (gnt)
  );

  assign req_ready = gnt;

  always_comb begin
    xfer_nxt       = '0;
    xfer_nxt.owner = gnt[1];
    xfer_nxt.dir   = gnt[1] ? req_dir[1] : req_dir[0];
    xfer_nxt.word  = gnt[1] ? req_data[2*WIDTH-1:WIDTH] : req_data[WIDTH-1:0];
  end

  assign ret_bit = xfer.dir ? ssbr_qr : ssbr_ql;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      capture <= '0;
      xfer    <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          cnt <= '0;
          if (acc_vld) begin
            xfer  <= xfer_nxt;
            state <= ST_SHIFT;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_SHIFT: begin
          capture[cnt] <= ret_bit;
          if (cnt == CNT_LAST) begin
            cnt   <= '0;
            state <= ST_DONE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          cnt   <= '0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Lane and response outputs decode from state/cnt and the latched transfer only.
  assign busy       = (state == ST_SHIFT);
  assign ssbr_shift = busy;
  assign ssbr_dir   = busy & xfer.dir;
  assign ssbr_d     = busy & xfer.word[cnt];
  assign rsp_valid  = (state == ST_DONE) ? (xfer.owner ? 2'b10 : 2'b01) : 2'b00;
  assign rsp_data   = (state == ST_DONE) ? capture : '0;

endmodule

// File: tb/tb_ssbr_lane_arb.sv
// Directed bench for ssbr_lane_arb with WIDTH = 4; honours SSBR_ARB_FIXED_PRIO_EN when defined.
module tb_ssbr_lane_arb;

  logic       clk;
  logic       rst;
  logic [1:0] req_valid;
  logic [1:0] req_ready;
  logic [1:0] req_dir;
  logic [7:0] req_data;
  logic [1:0] rsp_valid;
  logic [3:0] rsp_data;
  logic       ssbr_d;
  logic       ssbr_dir;
  logic       ssbr_shift;
  logic       ssbr_ql;
  logic       ssbr_qr;
  logic       busy;

  logic ql_tie, ql_const, qr_tie, qr_const;
  assign ssbr_ql = ql_tie ? ssbr_d : ql_const;
  assign ssbr_qr = qr_tie ? ssbr_d : qr_const;

  int errors;
  int checks;

  ssbr_lane_arb #(.WIDTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_dir    (req_dir),
    .req_data   (req_data),
    .rsp_valid  (rsp_valid),
    .rsp_data   (rsp_data),
    .ssbr_d     (ssbr_d),
    .ssbr_dir   (ssbr_dir),
    .ssbr_shift (ssbr_shift),
    .ssbr_ql    (ssbr_ql),
    .ssbr_qr    (ssbr_qr),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #2;
  endtask

  function automatic logic [31:0] outs_all;
    return 32'({req_ready, rsp_valid, rsp_data, ssbr_d, ssbr_dir, ssbr_shift, busy});
  endfunction

  logic [1:0] exp_gnt;
  logic [3:0] dexp;
  int         busy_cnt;

  initial begin
    errors    = 0;
    checks    = 0;
    rst       = 1'b1;
    req_valid = 2'b01;
    req_dir   = 2'b00;
    req_data  = 8'h0B;
    ql_tie    = 1'b1;
    ql_const  = 1'b0;
    qr_tie    = 1'b0;
    qr_const  = 1'b0;

    // Reset state: request present but nothing granted while rst is held.
    #3;
    check("rst_outs", outs_all(), 0);
    step;
    check("rst_outs2", outs_all(), 0);

    // Single request, dir 0, loopback through ql.
    rst = 1'b0;
    #1;
    check("t1_ready", 32'(req_ready), 32'h1);
    check("t1_busy0", 32'(busy), 0);
    step;
    req_valid = 2'b00;
    dexp = 4'b1011;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("t1_shift", 32'(ssbr_shift), 1);
      check("t1_d", 32'(ssbr_d), 32'(dexp[i]));
      check("t1_dir", 32'(ssbr_dir), 0);
      step;
    end
    #1;
    check("t1_rsp_v", 32'(rsp_valid), 32'h1);
    check("t1_rsp_d", 32'(rsp_data), 32'hB);
    check("t1_busy_done", 32'(busy), 0);
    check("t1_lane_idle", 32'({ssbr_d, ssbr_dir, ssbr_shift}), 0);
    step;
    check("t1_rsp_gone", 32'(rsp_valid), 0);

    // Both valid from reset, dir 1, qr held high; second grant in DONE.
    rst = 1'b1;
    step;
    rst       = 1'b0;
    ql_tie    = 1'b0;
    qr_const  = 1'b1;
    req_valid = 2'b11;
    req_dir   = 2'b11;
    req_data  = 8'hA5;
    #1;
    check("t2_gnt0", 32'(req_ready), 32'h1);
    step;
    req_valid = 2'b10;
    #1;
    check("t2_shift_nogrant", 32'(req_ready), 0);
    check("t2_dir", 32'(ssbr_dir), 1);
    check("t2_d0", 32'(ssbr_d), 1);
    repeat (4) step;
    check("t2_rsp0_v", 32'(rsp_valid), 32'h1);
    check("t2_gnt1_done", 32'(req_ready), 32'h2);
    check("t2_rsp0_d", 32'(rsp_data), 32'hF);
    step;
    req_valid = 2'b00;
    dexp = 4'hA;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("t2_d1", 32'(ssbr_d), 32'(dexp[i]));
      step;
    end
    #1;
    check("t2_rsp1_v", 32'(rsp_valid), 32'h2);
    check("t2_rsp1_d", 32'(rsp_data), 32'hF);
    step;

    // Requester 0 held, requester 1 pulsing at each grant opportunity.
    for (int k = 0; k < 4; k++) begin
      req_valid = 2'b11;
      #1;
`ifdef SSBR_ARB_FIXED_PRIO_EN
      exp_gnt = 2'b01;
`else
      exp_gnt = (k % 2 == 1) ? 2'b10 : 2'b01;
`endif
      check("t3_gnt", 32'(req_ready), 32'(exp_gnt));
      step;
      req_valid = 2'b01;
      repeat (4) step;
      req_valid = 2'b00;
      #1;
      check("t3_rsp", 32'(rsp_valid), 32'(exp_gnt));
    end
    step;
    check("t3_idle", 32'(busy), 0);

    // Reset at cnt = 2 aborts the transfer.
    ql_tie    = 1'b1;
    req_valid = 2'b01;
    req_dir   = 2'b00;
    req_data  = 8'h06;
    #1;
    check("t4_gnt", 32'(req_ready), 32'h1);
    step;
    req_valid = 2'b00;
    step;
    step;
    #1;
    check("t4_busy_pre", 32'(busy), 1);
    rst = 1'b1;
    #1;
    check("t4_rst_outs", outs_all(), 0);
    for (int i = 0; i < 3; i++) begin
      step;
      check("t4_rst_hold", outs_all(), 0);
    end
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      #1;
      check("t4_no_rsp", 32'(rsp_valid), 0);
      step;
    end
    req_valid = 2'b10;
    req_data  = 8'h90;
    #1;
    check("t4_fresh_gnt", 32'(req_ready), 32'h2);
    step;
    req_valid = 2'b00;
    repeat (4) step;
    check("t4_fresh_rsp_v", 32'(rsp_valid), 32'h2);
    check("t4_fresh_rsp_d", 32'(rsp_data), 32'h9);
    step;

    // Inputs changed after acceptance are ignored; dropped request never granted.
    qr_tie    = 1'b1;
    req_valid = 2'b01;
    req_dir   = 2'b01;
    req_data  = 8'h0C;
    #1;
    check("t5_gnt", 32'(req_ready), 32'h1);
    step;
    dexp     = 4'hC;
    busy_cnt = 0;
    for (int i = 1; i <= 7; i++) begin
      if (i == 1) begin
        req_data  = 8'h03;
        req_dir   = 2'b00;
        req_valid = 2'b00;
      end
      if (i == 2) req_valid = 2'b10;
      if (i == 3) req_valid = 2'b00;
      #1;
      busy_cnt += int'(busy);
      if (i <= 4) begin
        check("t5_d", 32'(ssbr_d), 32'(dexp[i-1]));
        check("t5_dir", 32'(ssbr_dir), 1);
      end
      if (i == 5) begin
        check("t5_rsp_v", 32'(rsp_valid), 32'h1);
        check("t5_rsp_d", 32'(rsp_data), 32'hC);
        check("t5_no_gnt", 32'(req_ready), 0);
      end
      if (i == 6) check("t5_rsp_gone", 32'(rsp_valid), 0);
      step;
    end
    check("t5_busy_cycles", 32'(busy_cnt), 4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
